// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: buffers line-aligned prefetches from the prefetcher, drops duplicates
// (queue, recently-issued filter, in-flight demand), squashes entries hit by demand misses.
module prefetch_issue_queue #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 8,
    parameter int FILTER_SIZE = 16,
    parameter int LOGLINE     = 6,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pf_address_i,
    input  logic                 pf_valid_i,
    input  logic [WIDTH-1:0]     demand_address_i,
    input  logic                 demand_valid_i,
    input  logic                 lo_ready_i,
    output logic [WIDTH-1:0]     lo_prefetch_address_o,
    output logic                 lo_prefetch_valid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] issued_count_o,
    output logic [CNT_WIDTH-1:0] dropped_count_o
);
    localparam int LW = WIDTH - LOGLINE;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    logic [LW-1:0]          r_line [DEPTH];
    logic [DEPTH-1:0]       r_vld;
    logic [DEPTH-1:0]       r_sq;
    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    logic [CW-1:0]          r_count;
    logic [LW-1:0]          r_flt_line [FILTER_SIZE];
    logic [FILTER_SIZE-1:0] r_flt_vld;
    logic [FW-1:0]          r_repl;
    logic [CNT_WIDTH-1:0]   r_issued;
    logic [CNT_WIDTH-1:0]   r_dropped;

    logic [LW-1:0] w_pf_line;
    logic [LW-1:0] w_dm_line;
    logic          w_q_hit;
    logic          w_f_hit;
    logic          w_dm_hit;
    logic          w_dup;
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_drop;
    logic          w_out_valid;
    logic          w_hs;
    logic          w_sq_pop;
    logic          w_deq;

    assign w_pf_line = pf_address_i[WIDTH-1:LOGLINE];
    assign w_dm_line = demand_address_i[WIDTH-1:LOGLINE];

    always_comb begin
        w_q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && !r_sq[i] && (r_line[i] == w_pf_line)) w_q_hit = 1'b1;
        end
        w_f_hit = 1'b0;
        for (int j = 0; j < FILTER_SIZE; j++) begin
            if (r_flt_vld[j] && (r_flt_line[j] == w_pf_line)) w_f_hit = 1'b1;
        end
    end

    assign w_dm_hit = demand_valid_i && (w_dm_line == w_pf_line);
    assign w_dup    = w_q_hit || w_f_hit || w_dm_hit;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // Full is judged on the pre-dequeue count, so a same-cycle pop never frees a slot.
    assign w_enq    = pf_valid_i && !w_dup && !w_full;
    assign w_drop   = pf_valid_i && (w_dup || w_full);

    // Valid is gated by rst so nothing can handshake while reset is asserted.
    assign w_out_valid = !rst && !w_empty && !r_sq[r_head];
    assign w_hs        = w_out_valid && lo_ready_i;
    assign w_sq_pop    = !w_empty && r_sq[r_head];
    assign w_deq       = w_hs || w_sq_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
            for (int j = 0; j < FILTER_SIZE; j++) r_flt_line[j] <= '0;
            r_vld     <= '0;
            r_sq      <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_flt_vld <= '0;
            r_repl    <= '0;
            r_issued  <= '0;
            r_dropped <= '0;
        end else begin
            if (demand_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_vld[i] && (r_line[i] == w_dm_line)) r_sq[i] <= 1'b1;
                end
            end
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_sq[r_head]  <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_line[r_tail] <= w_pf_line;
                r_vld[r_tail]  <= 1'b1;
                r_sq[r_tail]   <= 1'b0;
                r_tail         <= r_tail + 1'b1;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            if (w_hs) begin
                r_flt_line[r_repl] <= r_line[r_head];
                r_flt_vld[r_repl]  <= 1'b1;
                r_repl             <= r_repl + 1'b1;
                if (r_issued != '1) r_issued <= r_issued + 1'b1;
            end
            if (w_drop && (r_dropped != '1)) r_dropped <= r_dropped + 1'b1;
        end
    end

    assign lo_prefetch_valid_o   = w_out_valid;
    assign lo_prefetch_address_o = {r_line[r_head], {LOGLINE{1'b0}}};
    assign full_o                = w_full;
    assign empty_o               = w_empty;
    assign issued_count_o        = r_issued;
    assign dropped_count_o       = r_dropped;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue: each scenario task drives stimulus and checks inline.
module tb_prefetch_issue_queue;
    localparam int W  = 64;
    localparam int CN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pf_address_i;
    logic          pf_valid_i;
    logic [W-1:0]  demand_address_i;
    logic          demand_valid_i;
    logic          lo_ready_i;
    logic [W-1:0]  lo_prefetch_address_o;
    logic          lo_prefetch_valid_o;
    logic          full_o;
    logic          empty_o;
    logic [CN-1:0] issued_count_o;
    logic [CN-1:0] dropped_count_o;

    int checks = 0;
    int errors = 0;

    prefetch_issue_queue dut (
        .clk                   (clk),
        .rst                   (rst),
        .pf_address_i          (pf_address_i),
        .pf_valid_i            (pf_valid_i),
        .demand_address_i      (demand_address_i),
        .demand_valid_i        (demand_valid_i),
        .lo_ready_i            (lo_ready_i),
        .lo_prefetch_address_o (lo_prefetch_address_o),
        .lo_prefetch_valid_o   (lo_prefetch_valid_o),
        .full_o                (full_o),
        .empty_o               (empty_o),
        .issued_count_o        (issued_count_o),
        .dropped_count_o       (dropped_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a);
        pf_address_i = a;
        pf_valid_i   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pf_address_i = '0; pf_valid_i = 1'b0;
        demand_address_i = '0; demand_valid_i = 1'b0; lo_ready_i = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_o); end
        checks++; if (lo_prefetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", lo_prefetch_valid_o); end
        checks++; if (lo_prefetch_address_o !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", lo_prefetch_address_o); end
        checks++; if (issued_count_o !== 16'd0) begin errors++; $display("FAIL reset_issued got %0d exp 0", issued_count_o); end
        checks++; if (dropped_count_o !== 16'd0) begin errors++; $display("FAIL reset_dropped got %0d exp 0", dropped_count_o); end
    endtask

    task automatic test_in_order();
        lo_ready_i = 1'b1;
        push(64'h1000); step();
        checks++; if (lo_prefetch_valid_o !== 1'b1) begin errors++; $display("FAIL order_valid0 got %b exp 1", lo_prefetch_valid_o); end
        checks++; if (lo_prefetch_address_o !== 64'h1000) begin errors++; $display("FAIL order_addr0 got %h exp 1000", lo_prefetch_address_o); end
        push(64'h1040); step();
        checks++; if (lo_prefetch_address_o !== 64'h1040) begin errors++; $display("FAIL order_addr1 got %h exp 1040", lo_prefetch_address_o); end
        checks++; if (issued_count_o !== 16'd1) begin errors++; $display("FAIL order_issued1 got %0d exp 1", issued_count_o); end
        push(64'h1080); step();
        checks++; if (lo_prefetch_address_o !== 64'h1080) begin errors++; $display("FAIL order_addr2 got %h exp 1080", lo_prefetch_address_o); end
        pf_valid_i = 1'b0; step();
        checks++; if (issued_count_o !== 16'd3) begin errors++; $display("FAIL order_issued3 got %0d exp 3", issued_count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL order_empty got %b exp 1", empty_o); end
        lo_ready_i = 1'b0;
    endtask

    task automatic test_duplicate();
        lo_ready_i = 1'b0;
        push(64'h2000); step();
        push(64'h2010); step();
        pf_valid_i = 1'b0;
        checks++; if (dropped_count_o !== 16'd1) begin errors++; $display("FAIL dup_dropped1 got %0d exp 1", dropped_count_o); end
        checks++; if (lo_prefetch_address_o !== 64'h2000) begin errors++; $display("FAIL dup_addr got %h exp 2000", lo_prefetch_address_o); end
        lo_ready_i = 1'b1; step();
        checks++; if (issued_count_o !== 16'd4) begin errors++; $display("FAIL dup_issued got %0d exp 4", issued_count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL dup_single_entry got empty=%b exp 1", empty_o); end
        lo_ready_i = 1'b0;
        push(64'h2000); step();
        pf_valid_i = 1'b0;
        checks++; if (dropped_count_o !== 16'd2) begin errors++; $display("FAIL dup_filter_dropped got %0d exp 2", dropped_count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL dup_filter_empty got %b exp 1", empty_o); end
    endtask

    task automatic test_full();
        lo_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(64'h5000 + 64'(i) * 64'h40); step();
        end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_after8 got %b exp 1", full_o); end
        push(64'h5200); step();
        checks++; if (dropped_count_o !== 16'd3) begin errors++; $display("FAIL full_drop9 got %0d exp 3", dropped_count_o); end
        push(64'h6000); lo_ready_i = 1'b1; step();
        pf_valid_i = 1'b0;
        checks++; if (dropped_count_o !== 16'd4) begin errors++; $display("FAIL full_deq_drop got %0d exp 4", dropped_count_o); end
        checks++; if (issued_count_o !== 16'd5) begin errors++; $display("FAIL full_deq_issued got %0d exp 5", issued_count_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL full_deq_full got %b exp 0", full_o); end
        checks++; if (lo_prefetch_address_o !== 64'h5040) begin errors++; $display("FAIL full_deq_addr got %h exp 5040", lo_prefetch_address_o); end
        for (int i = 0; i < 7; i++) step();
        checks++; if (issued_count_o !== 16'd12) begin errors++; $display("FAIL full_drain_issued got %0d exp 12", issued_count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL full_drain_empty got %b exp 1", empty_o); end
        lo_ready_i = 1'b0;
    endtask

    task automatic test_squash();
        lo_ready_i = 1'b0;
        push(64'h3000); step();
        push(64'h3040); step();
        pf_valid_i = 1'b0;
        demand_address_i = 64'h3000; demand_valid_i = 1'b1; step();
        demand_valid_i = 1'b0;
        checks++; if (lo_prefetch_valid_o !== 1'b0) begin errors++; $display("FAIL squash_valid_low got %b exp 0", lo_prefetch_valid_o); end
        step();
        checks++; if (lo_prefetch_valid_o !== 1'b1) begin errors++; $display("FAIL squash_next_valid got %b exp 1", lo_prefetch_valid_o); end
        checks++; if (lo_prefetch_address_o !== 64'h3040) begin errors++; $display("FAIL squash_next_addr got %h exp 3040", lo_prefetch_address_o); end
        checks++; if (issued_count_o !== 16'd12) begin errors++; $display("FAIL squash_no_issue got %0d exp 12", issued_count_o); end
        checks++; if (dropped_count_o !== 16'd4) begin errors++; $display("FAIL squash_no_drop got %0d exp 4", dropped_count_o); end
        lo_ready_i = 1'b1; step();
        checks++; if (issued_count_o !== 16'd13) begin errors++; $display("FAIL squash_issued got %0d exp 13", issued_count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL squash_empty got %b exp 1", empty_o); end
        lo_ready_i = 1'b0;
    endtask

    task automatic test_same_cycle_demand();
        push(64'h4000); demand_address_i = 64'h4000; demand_valid_i = 1'b1; step();
        pf_valid_i = 1'b0; demand_valid_i = 1'b0;
        checks++; if (dropped_count_o !== 16'd5) begin errors++; $display("FAIL demand_drop got %0d exp 5", dropped_count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL demand_empty got %b exp 1", empty_o); end
        checks++; if (lo_prefetch_valid_o !== 1'b0) begin errors++; $display("FAIL demand_valid got %b exp 0", lo_prefetch_valid_o); end
    endtask

    task automatic test_reset_mid();
        lo_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(64'h7000 + 64'(i) * 64'h40); step();
        end
        push(64'h1000); step();
        pf_valid_i = 1'b0;
        checks++; if (dropped_count_o !== 16'd6) begin errors++; $display("FAIL mid_filter_drop got %0d exp 6", dropped_count_o); end
        checks++; if (lo_prefetch_address_o !== 64'h7000) begin errors++; $display("FAIL mid_head got %h exp 7000", lo_prefetch_address_o); end
        rst = 1'b1; lo_ready_i = 1'b1; #1;
        checks++; if (lo_prefetch_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_cycle_valid got %b exp 0", lo_prefetch_valid_o); end
        step();
        rst = 1'b0; lo_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty_o); end
        checks++; if (lo_prefetch_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", lo_prefetch_valid_o); end
        checks++; if (issued_count_o !== 16'd0) begin errors++; $display("FAIL mid_issued got %0d exp 0", issued_count_o); end
        checks++; if (dropped_count_o !== 16'd0) begin errors++; $display("FAIL mid_dropped got %0d exp 0", dropped_count_o); end
        step();
        checks++; if (lo_prefetch_valid_o !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %b exp 0", lo_prefetch_valid_o); end
        push(64'h1000); step();
        pf_valid_i = 1'b0;
        checks++; if (lo_prefetch_valid_o !== 1'b1) begin errors++; $display("FAIL mid_reaccept_valid got %b exp 1", lo_prefetch_valid_o); end
        checks++; if (lo_prefetch_address_o !== 64'h1000) begin errors++; $display("FAIL mid_reaccept_addr got %h exp 1000", lo_prefetch_address_o); end
        checks++; if (dropped_count_o !== 16'd0) begin errors++; $display("FAIL mid_reaccept_drop got %0d exp 0", dropped_count_o); end
        lo_ready_i = 1'b1; step();
        checks++; if (issued_count_o !== 16'd1) begin errors++; $display("FAIL mid_reissue got %0d exp 1", issued_count_o); end
        lo_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_duplicate();
        test_full();
        test_squash();
        test_same_cycle_demand();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
